ccg_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises one combinational benchmark circuit from the CCGRCG family. It drives all 2^N_IN input vectors in ascending order onto the circuit's `x` inputs. After each vector's settle window it folds the circuit's `f` outputs into a 32-bit MISR signature. At the end it compares the signature against an expected value. The block wraps any generated AIG netlist (e.g. 6 inputs / 19 outputs) for on-chip equivalence screening of RESYN variants.

---
 rtl/ccg_sweep_ctrl_pkg.sv | 29 ++
 rtl/ccg_sweep_ctrl_if.sv | 38 +++
 rtl/ccg_sweep_ctrl_misr.sv | 35 +++
 rtl/ccg_sweep_ctrl.sv | 134 +++++++++++++
 tb/tb_ccg_sweep_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ccg_sweep_ctrl_pkg.sv
// rtl/ccg_sweep_ctrl_pkg.sv - shared types, MISR constants and MISR step function for the sweep controller
//
// Contents:
//   sweep_state_t : controller FSM states
//   MISR_W        : signature width
//   MISR_POLY     : Galois feedback polynomial (CRC-32 generator)
//   MISR_SEED     : signature value at the start of every sweep
//   misr_step()   : one compaction step, shared by the MISR register and the top level
package ccg_sweep_pkg;

    localparam int          MISR_W    = 32;
    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    // Shift left, fold the feedback polynomial in when the bit leaving the top is set,
    // then XOR the parallel input word.
    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] cur,
                                                    input logic [MISR_W-1:0] d);
        return {cur[MISR_W-2:0], 1'b0} ^ (cur[MISR_W-1] ? MISR_POLY : '0) ^ d;
    endfunction

endpackage

// File: rtl/ccg_sweep_ctrl_if.sv
// rtl/ccg_sweep_ctrl_if.sv - control, circuit-under-test and result signals of the sweep controller
//
// Signals:
//   start, abort  : sweep control from the system
//   exp_sig       : expected signature, sampled when the sweep completes
//   f             : outputs of the combinational circuit under test
//   x             : registered input vector driven to the circuit under test
//   busy, done    : sweep status (done is a one-cycle pulse)
//   signature     : MISR value of the last completed sweep
//   pass          : signature matched exp_sig on the last completed sweep
// Modports:
//   master : system / circuit side
//   slave  : sweep controller side
interface ccg_sweep_ctrl_if #(
    parameter int N_IN  = 6,
    parameter int N_OUT = 19
);
    logic              start;
    logic              abort;
    logic [31:0]       exp_sig;
    logic [N_OUT-1:0]  f;
    logic [N_IN-1:0]   x;
    logic              busy;
    logic              done;
    logic [31:0]       signature;
    logic              pass;

    modport master (
        output start, abort, exp_sig, f,
        input  x, busy, done, signature, pass
    );

    modport slave (
        input  start, abort, exp_sig, f,
        output x, busy, done, signature, pass
    );

endinterface

// File: rtl/ccg_sweep_ctrl_misr.sv
// rtl/ccg_sweep_ctrl_misr.sv - 32-bit multiple-input signature register
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, loads the seed
//   init  : load the seed (wins over en)
//   en    : compact d into the signature this cycle
//   d     : parallel input word
//   q     : current signature
module ccg_misr
    import ccg_sweep_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              en,
    input  logic [MISR_W-1:0] d,
    output logic [MISR_W-1:0] q
);

    logic [MISR_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= MISR_SEED;
        end else if (init) begin
            r_q <= MISR_SEED;
        end else if (en) begin
            r_q <= misr_step(r_q, d);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/ccg_sweep_ctrl.sv
// rtl/ccg_sweep_ctrl.sv - exhaustive input sweep of a combinational circuit with MISR signature check
//
// Parameters:
//   N_IN   : circuit inputs; vectors 0 .. 2^N_IN-1 are applied in ascending order
//   N_OUT  : circuit outputs (<= 32), zero-extended into the MISR
//   SETTLE : cycles each vector is held before its outputs are sampled (>= 1)
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of ccg_sweep_ctrl_if (start/abort/exp_sig/f in, x/busy/done/signature/pass out)
module ccg_sweep_ctrl
    import ccg_sweep_pkg::*;
#(
    parameter int N_IN   = 6,
    parameter int N_OUT  = 19,
    parameter int SETTLE = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    ccg_sweep_ctrl_if.slave  bus
);

    localparam int              CNT_W         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE - 1);
    // One spare bit so the vector counter can never wrap inside a sweep.
    localparam logic [N_IN:0]    LAST_VEC      = {1'b0, {N_IN{1'b1}}};

    sweep_state_t      r_state;
    logic [N_IN:0]     r_vec;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_IN-1:0]   r_x;
    logic              r_busy;
    logic              r_done;
    logic [MISR_W-1:0] r_sig;
    logic              r_pass;

    logic [MISR_W-1:0] w_f_ext;
    logic [MISR_W-1:0] w_misr_q;
    logic [MISR_W-1:0] w_misr_next;
    logic [N_IN:0]     w_vec_inc;
    logic              w_misr_init;
    logic              w_misr_en;

    always_comb begin
        w_f_ext             = '0;
        w_f_ext[N_OUT-1:0]  = bus.f;
    end

    assign w_vec_inc   = r_vec + 1'b1;
    assign w_misr_next = misr_step(w_misr_q, w_f_ext);
    assign w_misr_init = (r_state == ST_IDLE) && bus.start && !bus.abort;
    assign w_misr_en   = (r_state == ST_SAMPLE) && !bus.abort;

    ccg_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (w_misr_init),
        .en    (w_misr_en),
        .d     (w_f_ext),
        .q     (w_misr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sig   <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_vec   <= '0;
                        r_cnt   <= SETTLE_RELOAD;
                        r_x     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) begin
                        r_x     <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (bus.abort) begin
                        r_x     <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_vec == LAST_VEC) begin
                        // Result registers see the MISR value that includes this last sample.
                        r_sig   <= w_misr_next;
                        r_pass  <= (w_misr_next == bus.exp_sig);
                        r_x     <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_vec   <= w_vec_inc;
                        r_x     <= w_vec_inc[N_IN-1:0];
                        r_cnt   <= SETTLE_RELOAD;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_x     <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.x         = r_x;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.signature = r_sig;
    assign bus.pass      = r_pass;

endmodule

// File: tb/tb_ccg_sweep_ctrl.sv
// tb/tb_ccg_sweep_ctrl.sv - scoreboard bench for ccg_sweep_ctrl at SETTLE=1 and SETTLE=3
module tb_ccg_sweep_ctrl;
    import ccg_sweep_pkg::*;

    typedef struct {
        logic [31:0] sig;
        logic        pass;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tb_start = 1'b0;
    logic        tb_abort = 1'b0;
    logic [31:0] tb_exp = '0;
    logic [18:0] tbl [64];
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ccg_sweep_ctrl_if #(.N_IN(6), .N_OUT(19)) ifa ();
    ccg_sweep_ctrl_if #(.N_IN(6), .N_OUT(19)) ifb ();

    assign ifa.start = tb_start;  assign ifb.start = tb_start;
    assign ifa.abort = tb_abort;  assign ifb.abort = tb_abort;
    assign ifa.exp_sig = tb_exp;  assign ifb.exp_sig = tb_exp;
    assign ifa.f = tbl[ifa.x];    assign ifb.f = tbl[ifb.x];

    ccg_sweep_ctrl #(.N_IN(6), .N_OUT(19), .SETTLE(1)) u_dut_s1 (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    ccg_sweep_ctrl #(.N_IN(6), .N_OUT(19), .SETTLE(3)) u_dut_s3 (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    exp_t        q0[$];
    exp_t        q1[$];
    bit          act [2];
    int          kst [2];
    int          sset [2] = '{1, 3};
    logic [31:0] last_sig [2];
    logic        last_pass [2];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[S=%0d] cyc=%0d: got %h, expected %h", nm, sset[i], cyc, got, exp);
        end
    endtask

    // Signature from the rules: seed, then per vector shift, polynomial feedback, XOR outputs.
    function automatic logic [31:0] ref_sig();
        logic [31:0] m;
        m = 32'hFFFFFFFF;
        for (int v = 0; v < 64; v++) begin
            m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ {13'h0, tbl[v]};
        end
        return m;
    endfunction

    task automatic mon(input int i, input logic [5:0] xo, input logic bo, input logic dn,
                       input logic [31:0] so, input logic po);
        int   d;
        exp_t e;
        bit   have;
        if (act[i]) begin
            d = cyc - kst[i];
            if (d < 64 * (sset[i] + 1)) begin
                chk("x", i, 32'(xo), 32'(d / (sset[i] + 1)));
                chk("busy", i, 32'(bo), 32'd1);
                chk("done_early", i, 32'(dn), 32'd0);
                chk("sig_hold", i, so, last_sig[i]);
            end else begin
                chk("done", i, 32'(dn), 32'd1);
                chk("busy_end", i, 32'(bo), 32'd0);
                chk("x_end", i, 32'(xo), 32'd0);
                have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (!have) begin
                    n_vec++; n_bad++;
                    $display("FAIL scoreboard_empty[S=%0d]: done with no expected entry", sset[i]);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk("signature", i, so, e.sig);
                    chk("pass", i, 32'(po), 32'(e.pass));
                    last_sig[i]  = e.sig;
                    last_pass[i] = e.pass;
                end
                act[i] = 1'b0;
            end
        end else begin
            chk("idle_x", i, 32'(xo), 32'd0);
            chk("idle_busy", i, 32'(bo), 32'd0);
            chk("idle_done", i, 32'(dn), 32'd0);
            chk("idle_sig", i, so, last_sig[i]);
            chk("idle_pass", i, 32'(po), 32'(last_pass[i]));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, ifa.x, ifa.busy, ifa.done, ifa.signature, ifa.pass);
            mon(1, ifb.x, ifb.busy, ifb.done, ifb.signature, ifb.pass);
        end
    end

    task automatic launch(input logic [31:0] es);
        logic [31:0] m;
        exp_t        e;
        m = ref_sig();
        e.sig = m;
        e.pass = (m == es);
        tb_exp = es;
        @(negedge clk);
        tb_start = 1'b1;
        q0.push_back(e);
        q1.push_back(e);
        @(posedge clk); #1;
        kst[0] = cyc; kst[1] = cyc;
        act[0] = 1'b1; act[1] = 1'b1;
        tb_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 600 && (act[0] || act[1]); t++) @(posedge clk);
        #1;
        if (act[0] || act[1]) begin
            n_vec++; n_bad++;
            $display("FAIL timeout: sweep did not complete");
            act[0] = 1'b0; act[1] = 1'b0;
            q0.delete(); q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_vec(input int v);
        int t;
        t = 0;
        @(negedge clk);
        while (!(act[0] && (cyc - kst[0]) == 2 * v) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_vec++; n_bad++;
            $display("FAIL timeout: vector %0d never reached", v);
        end
    endtask

    task automatic random_tbl();
        for (int v = 0; v < 64; v++) tbl[v] = 19'($urandom);
    endtask

    initial begin
        logic [31:0] h;
        for (int v = 0; v < 64; v++) tbl[v] = '0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; kst[i] = 0; last_sig[i] = '0; last_pass[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_x", 0, 32'(ifa.x), 32'd0);
        chk("rst_busy", 0, 32'(ifa.busy), 32'd0);
        chk("rst_sig", 0, ifa.signature, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reference-like circuit, exp_sig from the model, start pulsed again mid-sweep.
        for (int v = 0; v < 64; v++) begin
            h = 32'(v) * 32'h9E3779B1;
            tbl[v] = h[30:12];
        end
        launch(ref_sig());
        repeat (30) @(negedge clk);
        tb_start = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
        wait_idle();

        // All-zero outputs, exp_sig = 0.
        for (int v = 0; v < 64; v++) tbl[v] = '0;
        launch(32'h0);
        wait_idle();

        // Random circuits, matching and non-matching expected signatures.
        for (int n = 0; n < 4; n++) begin
            random_tbl();
            launch((n % 2 == 0) ? ref_sig() : $urandom);
            wait_idle();
        end

        // Abort at vector 20: no done, results unchanged.
        random_tbl();
        launch(ref_sig());
        wait_vec(20);
        tb_abort = 1'b1;
        @(posedge clk); #1;
        tb_abort = 1'b0;
        act[0] = 1'b0; act[1] = 1'b0;
        void'(q0.pop_back());
        void'(q1.pop_back());
        repeat (300) @(negedge clk);

        // start and abort together while idle: stays idle.
        tb_start = 1'b1; tb_abort = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0; tb_abort = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset at vector 40, between clock edges.
        random_tbl();
        launch(ref_sig());
        wait_vec(40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_x", 0, 32'(ifa.x), 32'd0);
        chk("arst_busy", 0, 32'(ifa.busy), 32'd0);
        chk("arst_done", 0, 32'(ifa.done), 32'd0);
        chk("arst_sig", 0, ifa.signature, 32'd0);
        chk("arst_pass", 0, 32'(ifa.pass), 32'd0);
        chk("arst_x", 1, 32'(ifb.x), 32'd0);
        chk("arst_busy", 1, 32'(ifb.busy), 32'd0);
        chk("arst_sig", 1, ifb.signature, 32'd0);
        act[0] = 1'b0; act[1] = 1'b0;
        q0.delete(); q1.delete();
        for (int i = 0; i < 2; i++) begin
            last_sig[i] = '0; last_pass[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        launch(ref_sig());
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
